matmul_seq_ctrl: RTL

Parametrised sequencing controller for the matrix-multiply datapath. It computes C = A×B, with A of size M×N, B of size N×P and C of size M×P, each held in its own single-port synchronous memory. For every output element it drives the memory read/write strobes, row-major addresses, multiplier load, shift-step count and accumulator controls. It is the generalised successor of the fixed 4-element controller: it adds arbitrary M/N/P, a configurable shift-step count, a busy/done handshake, and an optional accumulate mode (C += A×B).

---
 rtl/matmul_pkg.sv | 31 +++
 rtl/matmul_idx_cnt.sv | 51 +++++
 rtl/matmul_seq_ctrl.sv | 186 ++++++++++++++++++
 3 files changed

// File: rtl/matmul_pkg.sv
// Shared state encoding and index/address helpers for the matrix-multiply sequencer.
// The accumulate-mode states are only reachable when MATMUL_ACC_EN is defined.
package matmul_pkg;

    typedef enum logic [3:0] {
        ST_IDLE,
        ST_CLR,
        ST_CRD,
        ST_CLD,
        ST_RD,
        ST_LD,
        ST_SH,
        ST_ACC,
        ST_WR,
        ST_DONE
    } state_t;

    // A counter over n values needs at least one bit, even when n is 1.
    function automatic int cnt_width(input int n);
        return (n <= 1) ? 1 : $clog2(n);
    endfunction

    function automatic logic [31:0] row_major(
        input logic [31:0] row,
        input logic [31:0] col,
        input int unsigned ncols
    );
        return row * ncols + col;
    endfunction

endpackage

// File: rtl/matmul_idx_cnt.sv
// Nested i/j/k loop counters for the sequencer: k is the inner-product index,
// and (i,j) walks the output matrix row-major with j fastest.
module matmul_idx_cnt
    import matmul_pkg::*;
#(
    parameter int M = 4,
    parameter int N = 4,
    parameter int P = 4
) (
    input  logic                       clk,
    input  logic                       rst,
    input  logic                       clr,
    input  logic                       inc_k,
    input  logic                       next_elem,
    output logic [cnt_width(M)-1:0]    i,
    output logic [cnt_width(P)-1:0]    j,
    output logic [cnt_width(N)-1:0]    k,
    output logic                       last_k,
    output logic                       last_elem
);

    localparam int IW = cnt_width(M);
    localparam int JW = cnt_width(P);
    localparam int KW = cnt_width(N);

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            i <= '0;
            j <= '0;
            k <= '0;
        end else if (clr) begin
            i <= '0;
            j <= '0;
            k <= '0;
        end else if (next_elem) begin
            k <= '0;
            if (j == JW'(P - 1)) begin
                j <= '0;
                i <= (i == IW'(M - 1)) ? '0 : i + 1'b1;
            end else begin
                j <= j + 1'b1;
            end
        end else if (inc_k) begin
            k <= k + 1'b1;
        end
    end

    assign last_k    = (k == KW'(N - 1));
    assign last_elem = (i == IW'(M - 1)) && (j == JW'(P - 1));

endmodule

// File: rtl/matmul_seq_ctrl.sv
// Sequencing controller for C = A x B over single-port synchronous memories.
// Define MATMUL_ACC_EN to add accumulate mode (C += A x B) with acc_mode/acc_ld ports.
module matmul_seq_ctrl
    import matmul_pkg::*;
#(
    parameter int M           = 4,
    parameter int N           = 4,
    parameter int P           = 4,
    parameter int SHIFT_STEPS = 4,
    parameter int AW          = 8
) (
    input  logic                                clk,
    input  logic                                rst,
    input  logic                                start,
`ifdef MATMUL_ACC_EN
    input  logic                                acc_mode,
`endif
    output logic                                mem_a_rd,
    output logic                                mem_b_rd,
    output logic                                mem_c_rd,
    output logic                                mem_c_wr,
    output logic [AW-1:0]                       addr_a,
    output logic [AW-1:0]                       addr_b,
    output logic [AW-1:0]                       addr_c,
    output logic                                mult_ld,
    output logic [cnt_width(SHIFT_STEPS)-1:0]   shift_cnt,
    output logic                                acc_clr,
`ifdef MATMUL_ACC_EN
    output logic                                acc_ld,
`endif
    output logic                                acc_en,
    output logic                                busy,
    output logic                                done
);

    localparam int SW = cnt_width(SHIFT_STEPS);
    localparam int IW = cnt_width(M);
    localparam int JW = cnt_width(P);
    localparam int KW = cnt_width(N);

    state_t        state;
    state_t        nxt;
    logic [IW-1:0] i;
    logic [JW-1:0] j;
    logic [KW-1:0] k;
    logic          last_k;
    logic          last_elem;
    logic          elem_first_rd;

    logic [AW-1:0] addr_a_cur, addr_b_cur, addr_c_cur;
    logic [AW-1:0] addr_a_q, addr_b_q, addr_c_q;
    logic          c_addr_active;

`ifdef MATMUL_ACC_EN
    logic          acc_latched;
`endif

    matmul_idx_cnt #(
        .M (M),
        .N (N),
        .P (P)
    ) u_idx (
        .clk       (clk),
        .rst       (rst),
        .clr       (state == ST_IDLE),
        .inc_k     ((state == ST_ACC) && !last_k),
        .next_elem (state == ST_WR),
        .i         (i),
        .j         (j),
        .k         (k),
        .last_k    (last_k),
        .last_elem (last_elem)
    );

`ifdef MATMUL_ACC_EN
    assign elem_first_rd = acc_latched;
`else
    assign elem_first_rd = 1'b0;
`endif

    always_comb begin
        nxt = state;
        unique case (state)
            ST_IDLE: begin
                if (start) begin
`ifdef MATMUL_ACC_EN
                    nxt = acc_mode ? ST_CRD : ST_CLR;
`else
                    nxt = ST_CLR;
`endif
                end
            end
            ST_CLR:  nxt = ST_RD;
`ifdef MATMUL_ACC_EN
            ST_CRD:  nxt = ST_CLD;
            ST_CLD:  nxt = ST_RD;
`endif
            ST_RD:   nxt = ST_LD;
            ST_LD:   nxt = ST_SH;
            ST_SH:   nxt = (shift_cnt == SW'(SHIFT_STEPS - 1)) ? ST_ACC : ST_SH;
            ST_ACC:  nxt = last_k ? ST_WR : ST_RD;
            ST_WR: begin
                if (last_elem)          nxt = ST_DONE;
                else if (elem_first_rd) nxt = ST_CRD;
                else                    nxt = ST_CLR;
            end
            ST_DONE: nxt = ST_IDLE;
            default: nxt = ST_IDLE;
        endcase
    end

    // Strobes are registered from the next state so they line up with the state register.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state     <= ST_IDLE;
            mem_a_rd  <= 1'b0;
            mem_b_rd  <= 1'b0;
            mem_c_wr  <= 1'b0;
            mult_ld   <= 1'b0;
            shift_cnt <= '0;
            acc_clr   <= 1'b0;
            acc_en    <= 1'b0;
            busy      <= 1'b0;
            done      <= 1'b0;
`ifdef MATMUL_ACC_EN
            mem_c_rd    <= 1'b0;
            acc_ld      <= 1'b0;
            acc_latched <= 1'b0;
`endif
        end else begin
            state     <= nxt;
            mem_a_rd  <= (nxt == ST_RD);
            mem_b_rd  <= (nxt == ST_RD);
            mem_c_wr  <= (nxt == ST_WR);
            mult_ld   <= (nxt == ST_LD);
            shift_cnt <= (state == ST_SH && nxt == ST_SH) ? shift_cnt + 1'b1 : '0;
            acc_clr   <= (nxt == ST_CLR);
            acc_en    <= (nxt == ST_ACC);
            busy      <= (nxt != ST_IDLE);
            done      <= (nxt == ST_DONE);
`ifdef MATMUL_ACC_EN
            mem_c_rd  <= (nxt == ST_CRD);
            acc_ld    <= (nxt == ST_CLD);
            if (state == ST_IDLE && start) begin
                acc_latched <= acc_mode;
            end
`endif
        end
    end

`ifndef MATMUL_ACC_EN
    assign mem_c_rd = 1'b0;
`endif

    assign addr_a_cur = AW'(row_major(32'(i), 32'(k), N));
    assign addr_b_cur = AW'(row_major(32'(k), 32'(j), P));
    assign addr_c_cur = AW'(row_major(32'(i), 32'(j), P));

`ifdef MATMUL_ACC_EN
    assign c_addr_active = (state == ST_WR) || (state == ST_CRD);
`else
    assign c_addr_active = (state == ST_WR);
`endif

    // Addresses follow the indices while in use and otherwise replay the last value driven.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            addr_a_q <= '0;
            addr_b_q <= '0;
            addr_c_q <= '0;
        end else begin
            if (state == ST_RD) begin
                addr_a_q <= addr_a_cur;
                addr_b_q <= addr_b_cur;
            end
            if (c_addr_active) begin
                addr_c_q <= addr_c_cur;
            end
        end
    end

    assign addr_a = (state == ST_RD) ? addr_a_cur : addr_a_q;
    assign addr_b = (state == ST_RD) ? addr_b_cur : addr_b_q;
    assign addr_c = c_addr_active    ? addr_c_cur : addr_c_q;

endmodule
